pipeline_hazard_sequencer: RTL and testbench
============================================

PIPELINE_HAZARD_SEQUENCER -- requirements
Module: pipeline_hazard_sequencer

Interface
REQ-001 Parameter MAX_WAIT, default 4: cycles allowed in a wait state before timeout (legal range 2..15).
REQ-002 Parameter CNT_W, default 16: performance-counter width.
REQ-003 Clk  input  1  single clock, all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 IDU_LoadUse  input  1  ID instruction sources a register loaded by the EX instruction.
REQ-006 IDU_Control  input  1  ID instruction is a branch or jump.
REQ-007 IDU_Link  input  1  ID control instruction writes a link register (JAL class); valid only with IDU_Control.
REQ-008 MEM_BranchValid / MEM_BranchTaken  input  1 each  branch resolved in MEM, and its outcome.
REQ-009 WB_LinkDone  input  1  link-register write has committed in WB.
REQ-010 PCWrite / IFID_Write / IFID_Flush / IDEX_Bubble / PCRedirect  output  1 each  pipeline-register controls; PCRedirect selects the resolved target.
REQ-011 State  output  3  current FSM state encoding.
REQ-012 Timeout  output  1  sticky wait-timeout flag.
REQ-013 StallCycles / FlushCount  output  CNT_W each  performance counters.

Function
REQ-014 The FSM SHALL have states RST_HOLD=0, RUN=1, BR_WAIT=2, LINK_WAIT=3.
REQ-015 In RST_HOLD: PCWrite=0, IFID_Write=0, IFID_Flush=1, IDEX_Bubble=1, PCRedirect=0; next state RUN.
REQ-016 In RUN with IDU_LoadUse=1: PCWrite=0, IFID_Write=0, IDEX_Bubble=1 in the same cycle (combinational); remain in RUN.
REQ-017 LoadUse SHALL take priority over IDU_Control; the control instruction is not accepted during that cycle.
REQ-018 In RUN with IDU_Control=1 and IDU_LoadUse=0: PCWrite=1, IFID_Write=1, IDEX_Bubble=0; next state LINK_WAIT if IDU_Link=1, else BR_WAIT.
REQ-019 In RUN with no request: PCWrite=1, IFID_Write=1, all other controls 0.
REQ-020 In BR_WAIT and LINK_WAIT, default outputs are PCWrite=0, IFID_Write=0, IDEX_Bubble=1.
REQ-021 In BR_WAIT with MEM_BranchValid=1: PCWrite=MEM_BranchTaken, PCRedirect=MEM_BranchTaken, IFID_Flush=MEM_BranchTaken; next state RUN.
REQ-022 In LINK_WAIT with WB_LinkDone=1: PCWrite=1, PCRedirect=1, IFID_Flush=1; next state RUN.
REQ-023 A 4-bit wait counter SHALL clear on entry to a wait state and increment each wait cycle without resolution.
REQ-024 When the counter equals MAX_WAIT-1 without resolution: set Timeout, release as not-taken (PCWrite=1, no redirect, no flush), next state RUN.
REQ-025 Resolution and timeout in the same cycle: resolution wins and Timeout is not set.
REQ-026 Resolution inputs arriving in RUN or RST_HOLD SHALL be ignored.

Reset
REQ-027 Reset=1 SHALL force RST_HOLD at the next edge, and drive RST_HOLD outputs combinationally while asserted, including mid-wait.
REQ-028 Reset SHALL clear the wait counter, Timeout, StallCycles and FlushCount to 0.

Configuration
REQ-029 With HAZARD_SEQ_PERF_EN defined, StallCycles SHALL count cycles with PCWrite=0 outside RST_HOLD, saturating at all-ones.
REQ-030 With HAZARD_SEQ_PERF_EN defined, FlushCount SHALL count cycles with IFID_Flush=1 outside RST_HOLD, saturating at all-ones.
REQ-031 Without HAZARD_SEQ_PERF_EN, both counter ports remain present and are tied to 0.

Structure
REQ-032 State encodings and the MAX_WAIT default SHALL live in shared package hazard_pkg.
REQ-033 The saturating counter SHALL be sub-module sat_counter, instantiated twice.

Verification
REQ-034 Release reset, idle -> one cycle in RST_HOLD (Flush=1, Bubble=1), then RUN with PCWrite=1 and IFID_Write=1.
REQ-035 IDU_LoadUse=1 together with IDU_Control=1 for one cycle -> stall that cycle, State stays 1; next cycle Control alone -> State=2.
REQ-036 Branch accepted, MEM_BranchValid=1 and Taken=1 two cycles later -> PCRedirect=1, IFID_Flush=1, State returns to 1; with PERF_EN, FlushCount=1 and StallCycles=2.
REQ-037 JAL accepted (Link=1), WB_LinkDone after 3 cycles -> State=3 for 3 cycles, then a redirect-and-flush pulse.
REQ-038 Branch accepted, no resolution for 4 cycles -> Timeout=1 after the 4th wait cycle; resolving on that same cycle instead leaves Timeout=0.
REQ-039 Reset asserted during BR_WAIT -> State=0 next cycle, Timeout and counters at 0.

Source files
------------

// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM state
// encodings and the default wait-timeout length.
package hazard_pkg;

    typedef enum logic [2:0] {
        RST_HOLD  = 3'd0,
        RUN       = 3'd1,
        BR_WAIT   = 3'd2,
        LINK_WAIT = 3'd3
    } hazard_state_t;

    // Cycles a wait state may last before it is released as not-taken.
    localparam int MAX_WAIT_DEFAULT = 4;

    // Width of the wait-cycle counter (covers MAX_WAIT up to 15).
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Hazard request / pipeline control bundle between the decode, memory and
// writeback stages (master) and the hazard sequencer (slave).
interface pipeline_hazard_sequencer_if;

    // Hazard requests and resolution events
    logic IDU_LoadUse;
    logic IDU_Control;
    logic IDU_Link;
    logic MEM_BranchValid;
    logic MEM_BranchTaken;
    logic WB_LinkDone;

    // Pipeline register controls
    logic PCWrite;
    logic IFID_Write;
    logic IFID_Flush;
    logic IDEX_Bubble;
    logic PCRedirect;

    modport master (
        output IDU_LoadUse, IDU_Control, IDU_Link,
        output MEM_BranchValid, MEM_BranchTaken, WB_LinkDone,
        input  PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PCRedirect
    );

    modport slave (
        input  IDU_LoadUse, IDU_Control, IDU_Link,
        input  MEM_BranchValid, MEM_BranchTaken, WB_LinkDone,
        output PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PCRedirect
    );

endinterface

// File: rtl/pipeline_hazard_sequencer_sat_counter.sv
// Saturating up-counter: counts cycles with inc=1, holds at all-ones,
// cleared by synchronous reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    // Increment until all-ones, then hold
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline hazard sequencer: stalls on load-use, holds fetch while a branch
// or link write is pending, and releases with redirect/flush on resolution
// or as not-taken on timeout.
// Optional feature macro: HAZARD_SEQ_PERF_EN enables the stall and flush
// performance counters; without it both counter outputs read 0.
module pipeline_hazard_sequencer
    import hazard_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic                       Clk,
    input  logic                       Reset,
    pipeline_hazard_sequencer_if.slave hz,
    output logic [2:0]                 State,
    output logic                       Timeout,
    output logic [CNT_W-1:0]           StallCycles,
    output logic [CNT_W-1:0]           FlushCount
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MAX_WAIT - 1);

    hazard_state_t           state_reg, state_next;
    logic [WAIT_CNT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic                    timeout_reg, timeout_next;

    logic pc_write, ifid_write, ifid_flush, idex_bubble, pc_redirect;

    // State, wait counter and sticky timeout registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg    <= RST_HOLD;
            wait_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            timeout_reg  <= timeout_next;
        end
    end

    // Next-state and pipeline control decode
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        timeout_next  = timeout_reg;
        pc_write      = 1'b0;
        ifid_write    = 1'b0;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        pc_redirect   = 1'b0;

        case (state_reg)
            RST_HOLD: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                state_next  = RUN;
            end
            RUN: begin
                if (hz.IDU_LoadUse) begin
                    // Load-use wins; a coincident branch is retried next cycle
                    idex_bubble = 1'b1;
                end else begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    if (hz.IDU_Control) begin
                        wait_cnt_next = '0;
                        state_next    = hz.IDU_Link ? LINK_WAIT : BR_WAIT;
                    end
                end
            end
            BR_WAIT, LINK_WAIT: begin
                idex_bubble = 1'b1;
                if ((state_reg == BR_WAIT) && hz.MEM_BranchValid) begin
                    pc_write    = hz.MEM_BranchTaken;
                    pc_redirect = hz.MEM_BranchTaken;
                    ifid_flush  = hz.MEM_BranchTaken;
                    state_next  = RUN;
                end else if ((state_reg == LINK_WAIT) && hz.WB_LinkDone) begin
                    pc_write    = 1'b1;
                    pc_redirect = 1'b1;
                    ifid_flush  = 1'b1;
                    state_next  = RUN;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    // Give up waiting: continue down the fall-through path
                    pc_write     = 1'b1;
                    timeout_next = 1'b1;
                    state_next   = RUN;
                end else begin
                    wait_cnt_next = wait_cnt_reg + WAIT_CNT_W'(1);
                end
            end
            default: begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                state_next  = RST_HOLD;
            end
        endcase

        // Reset shows the hold-state controls immediately, whatever the state
        if (Reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            pc_redirect = 1'b0;
        end
    end

    assign hz.PCWrite     = pc_write;
    assign hz.IFID_Write  = ifid_write;
    assign hz.IFID_Flush  = ifid_flush;
    assign hz.IDEX_Bubble = idex_bubble;
    assign hz.PCRedirect  = pc_redirect;
    assign State          = state_reg;
    assign Timeout        = timeout_reg;

`ifdef HAZARD_SEQ_PERF_EN
    // Index 0 counts stalled fetch cycles, index 1 counts flush cycles
    logic [1:0]       perf_inc;
    logic [CNT_W-1:0] perf_count [2];

    assign perf_inc[0] = (state_reg != RST_HOLD) && !pc_write;
    assign perf_inc[1] = (state_reg != RST_HOLD) && ifid_flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf
            sat_counter #(.W(CNT_W)) u_cnt (
                .Clk   (Clk),
                .Reset (Reset),
                .inc   (perf_inc[gi]),
                .count (perf_count[gi])
            );
        end
    endgenerate

    assign StallCycles = perf_count[0];
    assign FlushCount  = perf_count[1];
`else
    assign StallCycles = '0;
    assign FlushCount  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Self-checking bench for pipeline_hazard_sequencer. Each scenario is a
// table of {inputs, expected outputs} rows; expected values are queued when a
// row is driven and popped when the outputs are sampled on the falling edge.
// Expected packing: {State[2:0], PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, PCRedirect}
module tb_pipeline_hazard_sequencer;

    logic        Clk;
    logic        Reset;
    logic [2:0]  State;
    logic        Timeout;
    logic [15:0] StallCycles;
    logic [15:0] FlushCount;

    int tests    = 0;
    int failures = 0;

    logic [7:0] exp_q [$];

    pipeline_hazard_sequencer_if hz_if ();

    pipeline_hazard_sequencer #(.MAX_WAIT(4), .CNT_W(16)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .hz          (hz_if),
        .State       (State),
        .Timeout     (Timeout),
        .StallCycles (StallCycles),
        .FlushCount  (FlushCount)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Input encodings {Reset, LoadUse, Control, Link, BranchValid, BranchTaken, LinkDone}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_RST  = 7'b1000000;
    localparam logic [6:0] I_LU   = 7'b0100000;
    localparam logic [6:0] I_CTL  = 7'b0010000;
    localparam logic [6:0] I_LNK  = 7'b0001000;
    localparam logic [6:0] I_BV   = 7'b0000100;
    localparam logic [6:0] I_BT   = 7'b0000010;
    localparam logic [6:0] I_LD   = 7'b0000001;

    // Expected output vectors
    localparam logic [7:0] E_HOLD     = 8'b000_00110;
    localparam logic [7:0] E_RUN      = 8'b001_11000;
    localparam logic [7:0] E_LU       = 8'b001_00010;
    localparam logic [7:0] E_BW       = 8'b010_00010;
    localparam logic [7:0] E_BTK      = 8'b010_10111;
    localparam logic [7:0] E_BTO      = 8'b010_10010;
    localparam logic [7:0] E_LW       = 8'b011_00010;
    localparam logic [7:0] E_LDN      = 8'b011_10111;
    localparam logic [7:0] E_BW_RST   = 8'b010_00110;
    localparam logic [7:0] E_RUN_RST  = 8'b001_00110;

`ifdef HAZARD_SEQ_PERF_EN
    localparam logic [15:0] EXP_STALL = 16'd2;
    localparam logic [15:0] EXP_FLUSH = 16'd1;
`else
    localparam logic [15:0] EXP_STALL = 16'd0;
    localparam logic [15:0] EXP_FLUSH = 16'd0;
`endif

    function automatic logic [7:0] observed();
        return {State, hz_if.PCWrite, hz_if.IFID_Write, hz_if.IFID_Flush,
                hz_if.IDEX_Bubble, hz_if.PCRedirect};
    endfunction

    // Apply one row of inputs and queue the outputs it should produce
    task automatic drive(input logic [6:0] in_bits, input logic [7:0] exp_bits);
        Reset                 = in_bits[6];
        hz_if.IDU_LoadUse     = in_bits[5];
        hz_if.IDU_Control     = in_bits[4];
        hz_if.IDU_Link        = in_bits[3];
        hz_if.MEM_BranchValid = in_bits[2];
        hz_if.MEM_BranchTaken = in_bits[1];
        hz_if.WB_LinkDone     = in_bits[0];
        exp_q.push_back(exp_bits);
    endtask

    task automatic test_reset();
        logic [14:0] rows [3];
        logic [7:0]  got, want;
        rows = '{{I_RST, E_HOLD}, {I_NONE, E_HOLD}, {I_NONE, E_RUN}};
        for (int i = 0; i < 3; i++) begin
            drive(rows[i][14:8], rows[i][7:0]);
            @(negedge Clk);
            got  = observed();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset row %0d: got %b expected %b", i, got, want);
            end
            if (i == 0) begin
                tests++;
                if ({Timeout, StallCycles, FlushCount} !== 33'd0) begin
                    failures++;
                    $display("FAIL reset_clear: timeout=%b stall=%0d flush=%0d expected all 0",
                             Timeout, StallCycles, FlushCount);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_load_use_priority();
        logic [14:0] rows [6];
        logic [7:0]  got, want;
        rows = '{{I_LU | I_CTL, E_LU}, {I_CTL, E_RUN}, {I_NONE, E_BW},
                 {I_BV, E_BW}, {I_BV | I_BT | I_LD, E_RUN}, {I_NONE, E_RUN}};
        for (int i = 0; i < 6; i++) begin
            drive(rows[i][14:8], rows[i][7:0]);
            @(negedge Clk);
            got  = observed();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                failures++;
                $display("FAIL load_use row %0d: got %b expected %b", i, got, want);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_branch_taken();
        logic [14:0] rows [7];
        logic [7:0]  got, want;
        rows = '{{I_RST, E_RUN_RST}, {I_NONE, E_HOLD}, {I_CTL, E_RUN}, {I_NONE, E_BW},
                 {I_NONE, E_BW}, {I_BV | I_BT, E_BTK}, {I_NONE, E_RUN}};
        for (int i = 0; i < 7; i++) begin
            drive(rows[i][14:8], rows[i][7:0]);
            @(negedge Clk);
            got  = observed();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                failures++;
                $display("FAIL branch_taken row %0d: got %b expected %b", i, got, want);
            end
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        tests++;
        if (StallCycles !== EXP_STALL) begin
            failures++;
            $display("FAIL stall_count: got %0d expected %0d", StallCycles, EXP_STALL);
        end
        tests++;
        if (FlushCount !== EXP_FLUSH) begin
            failures++;
            $display("FAIL flush_count: got %0d expected %0d", FlushCount, EXP_FLUSH);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_jal();
        logic [14:0] rows [5];
        logic [7:0]  got, want;
        rows = '{{I_CTL | I_LNK, E_RUN}, {I_NONE, E_LW}, {I_BV | I_BT, E_LW},
                 {I_LD, E_LDN}, {I_NONE, E_RUN}};
        for (int i = 0; i < 5; i++) begin
            drive(rows[i][14:8], rows[i][7:0]);
            @(negedge Clk);
            got  = observed();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                failures++;
                $display("FAIL jal row %0d: got %b expected %b", i, got, want);
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_resolve_at_limit();
        logic [14:0] rows [6];
        logic [7:0]  got, want;
        rows = '{{I_CTL, E_RUN}, {I_NONE, E_BW}, {I_NONE, E_BW}, {I_NONE, E_BW},
                 {I_BV | I_BT, E_BTK}, {I_NONE, E_RUN}};
        for (int i = 0; i < 6; i++) begin
            drive(rows[i][14:8], rows[i][7:0]);
            @(negedge Clk);
            got  = observed();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                failures++;
                $display("FAIL resolve_at_limit row %0d: got %b expected %b", i, got, want);
            end
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        tests++;
        if (Timeout !== 1'b0) begin
            failures++;
            $display("FAIL resolve_at_limit_timeout: got %b expected 0", Timeout);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_timeout();
        logic [14:0] rows [6];
        logic [7:0]  got, want;
        rows = '{{I_CTL, E_RUN}, {I_NONE, E_BW}, {I_NONE, E_BW}, {I_NONE, E_BW},
                 {I_NONE, E_BTO}, {I_NONE, E_RUN}};
        for (int i = 0; i < 6; i++) begin
            drive(rows[i][14:8], rows[i][7:0]);
            @(negedge Clk);
            got  = observed();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                failures++;
                $display("FAIL timeout row %0d: got %b expected %b", i, got, want);
            end
            @(posedge Clk); #1;
        end
        @(negedge Clk);
        tests++;
        if (Timeout !== 1'b1) begin
            failures++;
            $display("FAIL timeout_flag: got %b expected 1", Timeout);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid_wait();
        logic [14:0] rows [5];
        logic [7:0]  got, want;
        rows = '{{I_CTL, E_RUN}, {I_NONE, E_BW}, {I_RST, E_BW_RST},
                 {I_NONE, E_HOLD}, {I_NONE, E_RUN}};
        for (int i = 0; i < 5; i++) begin
            drive(rows[i][14:8], rows[i][7:0]);
            @(negedge Clk);
            got  = observed();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid_wait row %0d: got %b expected %b", i, got, want);
            end
            if (i == 3) begin
                tests++;
                if ({Timeout, StallCycles, FlushCount} !== 33'd0) begin
                    failures++;
                    $display("FAIL reset_mid_wait_clear: timeout=%b stall=%0d flush=%0d expected all 0",
                             Timeout, StallCycles, FlushCount);
                end
            end
            @(posedge Clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] rows [8];
        logic [7:0]  got, want;
        rows = '{{I_CTL, E_RUN}, {I_BV, E_BW}, {I_CTL | I_LNK, E_RUN}, {I_LD, E_LDN},
                 {I_CTL, E_RUN}, {I_NONE, E_BW}, {I_BV | I_BT, E_BTK}, {I_NONE, E_RUN}};
        for (int i = 0; i < 8; i++) begin
            drive(rows[i][14:8], rows[i][7:0]);
            @(negedge Clk);
            got  = observed();
            want = exp_q.pop_front();
            tests++;
            if (got !== want) begin
                failures++;
                $display("FAIL back_to_back row %0d: got %b expected %b", i, got, want);
            end
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        drive(I_RST, E_HOLD);
        void'(exp_q.pop_front());
        repeat (2) @(posedge Clk);
        #1;
        test_reset();
        test_load_use_priority();
        test_branch_taken();
        test_jal();
        test_resolve_at_limit();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
